pingpong_frame_ctrl: RTL
========================

Name: pingpong_frame_ctrl

Overview:
- Sequences the shared dual-port sample RAM (one write port, one read port, registered 1-cycle read) as a ping-pong frame buffer.
- The audio sample stream fills one half (bank) while the FFT/visualizer consumer reads the other.
- Banks swap when a frame is complete and the reader has released its bank.
- Sits between the audio capture front end and the RAM, and presents a frame-relative read interface to the consumer.

Parameters:
- DATA_WIDTH, 32: sample/RAM word width.
- ADDR_LENGTH, 14: RAM address width. Bank select is the MSB; each bank holds 2^(ADDR_LENGTH-1) words.
- FRAME_LEN, 1024: samples per frame. Must be in 2..2^(ADDR_LENGTH-1); elaboration error otherwise.
- DROP_W, 16: width of the dropped-sample counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample present.
- in_data  in  DATA_WIDTH  input sample.
- in_ready  out  1  sample accepted this cycle when in_valid & in_ready.
- rd_start  in  1  consumer claims the available frame.
- rd_req  in  1  read request.
- rd_index  in  ADDR_LENGTH-1  frame-relative read index.
- rd_done  in  1  consumer releases its bank.
- rd_valid  out  1  rd_data valid (one cycle after accepted rd_req).
- rd_data  out  DATA_WIDTH  read data (pass-through of mem_rddata).
- frame_avail  out  1  complete, unclaimed frame ready.
- rd_busy  out  1  reader holds a bank.
- overrun  out  1  one-cycle pulse: unclaimed frame replaced by a newer one.
- drop_cnt  out  DROP_W  saturating count of samples refused while in_ready=0.
- mem_we  out  1  RAM write enable.
- mem_wraddr  out  ADDR_LENGTH  RAM write address.
- mem_wrdata  out  DATA_WIDTH  RAM write data.
- mem_rdaddr  out  ADDR_LENGTH  RAM read address.
- mem_rddata  in  DATA_WIDTH  RAM read data.

Behaviour:

Reset
- Synchronous reset is honoured at any time, including mid-frame or mid-read. All state returns to reset values:
  - wr_bank=0, wr_cnt=0, writer FSM in FILL.
  - rd_bank=1, reader FSM in IDLE.
  - frame_avail=0, rd_valid=0, overrun=0, drop_cnt=0.
- RAM contents are not cleared. A partially written frame is discarded.

Writer FSM {FILL, WAIT}
- in_ready = (state==FILL).
- mem_we = in_valid & in_ready.
- mem_wraddr = {wr_bank, wr_cnt}; mem_wrdata = in_data. All three are combinational.
- In FILL, an accepted sample increments wr_cnt. The accept at wr_cnt==FRAME_LEN-1 moves the FSM to WAIT and clears wr_cnt.
- In WAIT, no writes occur. Each cycle with in_valid=1 increments drop_cnt, saturating at all-ones. Samples are never back-pressured upstream.

Swap
- Condition: writer==WAIT && reader==IDLE && !(rd_start && frame_avail).
- Registered effect on the next edge:
  - rd_bank <= wr_bank; wr_bank <= ~wr_bank.
  - Writer returns to FILL.
  - frame_avail <= 1.
  - overrun pulses if frame_avail was already 1. Newest frame wins.
- Swap latency: earliest one cycle after the final sample is written. No sample is accepted in the WAIT cycle.

Reader FSM {IDLE, READ}
- rd_busy = (state==READ).
- IDLE, with rd_start && frame_avail:
  - Go to READ and clear frame_avail.
  - rd_start has priority over a same-cycle swap; the swap defers one cycle.
- IDLE, with rd_start && !frame_avail: ignored.
- READ:
  - mem_rdaddr = {rd_bank, rd_index}, combinational.
  - rd_req with rd_index < FRAME_LEN is accepted; rd_valid=1 on the next cycle and rd_data = mem_rddata that cycle.
  - rd_req with rd_index >= FRAME_LEN, or rd_req while IDLE, is dropped (no rd_valid).
  - Back-to-back rd_req is allowed: one result per cycle, in order.
- rd_done in READ moves to IDLE on the next edge. A pending swap may fire the cycle after.
- rd_done in IDLE is ignored. rd_done and rd_req in the same cycle: the request is still served.

Invariants
- wr_bank != rd_bank whenever reader==READ.
- The RAM write and read ports never address the same bank while reader==READ.

Decomposition:
- Shared package holds:
  - Writer state encodings FILL/WAIT.
  - Reader state encodings IDLE/READ.
  - A BANK_AW = ADDR_LENGTH-1 localparam helper.
- One natural sub-module: sat_counter (parameterised width, inc, clear, saturate), used for drop_cnt.
- The writer and reader FSMs stay in the top level.

Test Plan:
1. Reset, then stream 1024 samples with in_valid held high (data = index):
   - in_ready falls after the 1024th sample.
   - frame_avail rises 2 cycles after the last write.
   - The next write goes to mem_wraddr 0x2000.
2. rd_start, then rd_req for indices 0..1023:
   - rd_valid follows each request by one cycle.
   - mem_rdaddr = 0x0000..0x03FF.
   - rd_data equals the index.
   - rd_req with index 1024 produces no rd_valid.
3. Reader holds READ while the writer fills bank 1:
   - Writer enters WAIT.
   - 5 further valid samples give drop_cnt=5.
   - rd_done produces a swap 2 cycles later (rd_bank=1, wr_bank=0).
4. Reader stays idle across two full frames:
   - Second swap pulses overrun once.
   - frame_avail stays high; rd_bank points to the newest frame.
5. rd_start asserted in the exact cycle the swap condition holds:
   - Reader enters READ on the old rd_bank.
   - Swap fires only after rd_done.
6. Reset asserted mid-frame (wr_cnt=500) and mid-read:
   - All outputs return to reset values next cycle.
   - drop_cnt=0; first write goes to address 0x0000.
   - Also: force drop_cnt to all-ones and confirm it holds at saturation.

Source files
------------

// File: rtl/pingpong_frame_ctrl_pkg.sv
// Shared types and helpers for the ping-pong frame buffer controller.
package pingpong_frame_ctrl_pkg;

   // Writer: filling the write bank, or holding a complete frame until the swap.
   typedef enum logic [0:0] {
      WrFill = 1'b0,
      WrWait = 1'b1
   } wr_state_e;

   // Reader: no bank held, or holding the read bank for the consumer.
   typedef enum logic [0:0] {
      RdIdle = 1'b0,
      RdRead = 1'b1
   } rd_state_e;

   // Address width inside one bank; the RAM address MSB selects the bank.
   function automatic int unsigned bank_aw(input int unsigned addr_length);
      return addr_length - 1;
   endfunction

endpackage

// File: rtl/pingpong_frame_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clear,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: clear wins, otherwise step up until all-ones.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (inc && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pingpong_frame_ctrl.sv
// Ping-pong frame buffer sequencer for a shared dual-port sample RAM.
// The capture stream fills the write bank while the consumer reads the other;
// banks swap once a frame is complete and the reader has released its bank.
module pingpong_frame_ctrl
   import pingpong_frame_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_LENGTH = 14,
   parameter int unsigned FRAME_LEN   = 1024,
   parameter int unsigned DROP_W      = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   // Sample stream
   input  logic                   in_valid,
   input  logic [DATA_WIDTH-1:0]  in_data,
   output logic                   in_ready,
   // Consumer interface
   input  logic                   rd_start,
   input  logic                   rd_req,
   input  logic [ADDR_LENGTH-2:0] rd_index,
   input  logic                   rd_done,
   output logic                   rd_valid,
   output logic [DATA_WIDTH-1:0]  rd_data,
   output logic                   frame_avail,
   output logic                   rd_busy,
   output logic                   overrun,
   output logic [DROP_W-1:0]      drop_cnt,
   // RAM ports
   output logic                   mem_we,
   output logic [ADDR_LENGTH-1:0] mem_wraddr,
   output logic [DATA_WIDTH-1:0]  mem_wrdata,
   output logic [ADDR_LENGTH-1:0] mem_rdaddr,
   input  logic [DATA_WIDTH-1:0]  mem_rddata
);

   localparam int unsigned BANK_AW = bank_aw(ADDR_LENGTH);

   // A frame must fit in one bank and be at least two samples long.
   if ((FRAME_LEN < 2) || (FRAME_LEN > (1 << BANK_AW))) begin : g_bad_frame_len
      $error("pingpong_frame_ctrl: FRAME_LEN out of range for ADDR_LENGTH");
   end

   localparam logic [BANK_AW-1:0] LAST_IDX    = BANK_AW'(FRAME_LEN - 1);
   localparam logic [BANK_AW:0]   FRAME_LEN_W = (BANK_AW + 1)'(FRAME_LEN);

   wr_state_e          wr_state_q, wr_state_d;
   logic [BANK_AW-1:0] wr_cnt_q, wr_cnt_d;
   logic               wr_bank_q, wr_bank_d;

   rd_state_e          rd_state_q, rd_state_d;
   logic               rd_bank_q, rd_bank_d;
   logic               frame_avail_q, frame_avail_d;
   logic               rd_valid_q, rd_valid_d;
   logic               overrun_q, overrun_d;

   logic               wr_accept;
   logic               claim;
   logic               swap;
   logic               rd_accept;
   logic               drop_inc;

   // Handshake and event decode shared by both FSMs.
   always_comb begin
      in_ready  = (wr_state_q == WrFill);
      wr_accept = in_valid && in_ready;
      claim     = (rd_state_q == RdIdle) && rd_start && frame_avail_q;
      // A same-cycle claim takes the current frame; the swap waits a cycle.
      swap      = (wr_state_q == WrWait) && (rd_state_q == RdIdle) && !claim;
      rd_accept = (rd_state_q == RdRead) && rd_req && ({1'b0, rd_index} < FRAME_LEN_W);
      drop_inc  = (wr_state_q == WrWait) && in_valid;
   end

   // Writer next state: count accepted samples, park in WrWait until the swap.
   always_comb begin
      wr_state_d = wr_state_q;
      wr_cnt_d   = wr_cnt_q;
      wr_bank_d  = wr_bank_q;
      unique case (wr_state_q)
         WrFill: begin
            if (wr_accept) begin
               if (wr_cnt_q == LAST_IDX) begin
                  wr_state_d = WrWait;
                  wr_cnt_d   = '0;
               end else begin
                  wr_cnt_d = wr_cnt_q + 1'b1;
               end
            end
         end
         WrWait: begin
            if (swap) begin
               wr_state_d = WrFill;
               wr_bank_d  = ~wr_bank_q;
            end
         end
         default: wr_state_d = WrFill;
      endcase
   end

   // Reader next state plus frame bookkeeping and read-data qualifier.
   always_comb begin
      rd_state_d    = rd_state_q;
      rd_bank_d     = rd_bank_q;
      frame_avail_d = frame_avail_q;
      overrun_d     = 1'b0;
      rd_valid_d    = rd_accept;
      unique case (rd_state_q)
         RdIdle: if (claim) rd_state_d = RdRead;
         RdRead: if (rd_done) rd_state_d = RdIdle;
         default: rd_state_d = RdIdle;
      endcase
      if (swap) begin
         rd_bank_d     = wr_bank_q;
         frame_avail_d = 1'b1;
         // Newest frame replaces one the consumer never claimed.
         overrun_d     = frame_avail_q;
      end else if (claim) begin
         frame_avail_d = 1'b0;
      end
   end

   // State registers; reset discards any partial frame and any held bank.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_state_q    <= WrFill;
         wr_cnt_q      <= '0;
         wr_bank_q     <= 1'b0;
         rd_state_q    <= RdIdle;
         rd_bank_q     <= 1'b1;
         frame_avail_q <= 1'b0;
         rd_valid_q    <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         wr_state_q    <= wr_state_d;
         wr_cnt_q      <= wr_cnt_d;
         wr_bank_q     <= wr_bank_d;
         rd_state_q    <= rd_state_d;
         rd_bank_q     <= rd_bank_d;
         frame_avail_q <= frame_avail_d;
         rd_valid_q    <= rd_valid_d;
         overrun_q     <= overrun_d;
      end
   end

   sat_counter #(
      .WIDTH (DROP_W)
   ) u_drop_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (drop_inc),
      .clear (1'b0),
      .count (drop_cnt)
   );

   // RAM port drive and consumer-facing outputs.
   always_comb begin
      mem_we      = wr_accept;
      mem_wraddr  = {wr_bank_q, wr_cnt_q};
      mem_wrdata  = in_data;
      mem_rdaddr  = {rd_bank_q, rd_index};
      rd_data     = mem_rddata;
      rd_valid    = rd_valid_q;
      frame_avail = frame_avail_q;
      rd_busy     = (rd_state_q == RdRead);
      overrun     = overrun_q;
   end

endmodule
